// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy marks an operation in flight.
// Results are committed to HI/LO only on the completion edge.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic [31:0]      a_q,     a_d;
  logic [31:0]      b_q,     b_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;

  logic [63:0] prod_c;
  logic [31:0] ext_a_c, ext_b_c;
  logic        sgn_c;
  logic [31:0] abs_a_c, abs_b_c, uq_c, ur_c;
  logic [31:0] res_hi_c, res_lo_c;

  // Result datapath from latched operands; op_q[0] selects unsigned, op_q[1] selects divide.
  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    ext_a_c  = op_q[0] ? 32'd0 : {32{a_q[31]}};
    ext_b_c  = op_q[0] ? 32'd0 : {32{b_q[31]}};
    prod_c   = {ext_a_c, a_q} * {ext_b_c, b_q};
    sgn_c    = ~op_q[0];
    abs_a_c  = (sgn_c && a_q[31]) ? (32'd0 - a_q) : a_q;
    abs_b_c  = (sgn_c && b_q[31]) ? (32'd0 - b_q) : b_q;
    uq_c     = 32'd0;
    ur_c     = 32'd0;
    if (b_q != 32'd0) begin
      uq_c = abs_a_c / abs_b_c;
      ur_c = abs_a_c % abs_b_c;
    end
    res_hi_c = prod_c[63:32];
    res_lo_c = prod_c[31:0];
    if (op_q[1]) begin
      if (b_q == 32'd0) begin
        res_hi_c = a_q;
        res_lo_c = 32'hFFFF_FFFF;
      end else begin
        res_lo_c = (sgn_c && (a_q[31] ^ b_q[31])) ? (32'd0 - uq_c) : uq_c;
        res_hi_c = (sgn_c && a_q[31]) ? (32'd0 - ur_c) : ur_c;
      end
    end
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!md_op[2]) begin
            op_d    = md_op[1:0];
            a_d     = A;
            b_d     = B;
            cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = S_RUN;
          end else if (md_op == OP_MTHI) begin
            hi_d = A;
          end else if (md_op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_hi_c;
          lo_d    = res_lo_c;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, hand sequences, and random ops vs a 64-bit arithmetic model.
module tb_md_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic int unsigned op_cycles(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return MULT_N;
    if (op == 3'd2 || op == 3'd3) return DIV_N;
    return 0;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_in, input logic [31:0] lo_in,
                       output logic [31:0] hi_out, output logic [31:0] lo_out);
    longint sa, sb, q, r;
    logic [63:0] up;
    hi_out = hi_in;
    lo_out = lo_in;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin q = sa * sb; hi_out = q[63:32]; lo_out = q[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; hi_out = up[63:32]; lo_out = up[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin hi_out = a; lo_out = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; hi_out = r[31:0]; lo_out = q[31:0]; end
      end
      3'd3: begin
        if (b == 32'd0) begin hi_out = a; lo_out = 32'hFFFF_FFFF; end
        else begin hi_out = a % b; lo_out = a / b; end
      end
      3'd4: hi_out = a;
      3'd5: lo_out = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; leaves start low at the next negedge (first busy cycle).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; md_op = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(input string name, input int unsigned exp_n,
                           input logic [31:0] old_hi, input logic [31:0] old_lo);
    int unsigned n = 0;
    logic stable = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      if (HI !== old_hi || LO !== old_lo) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    check32({name, " busy cycles"}, n, exp_n);
    check32({name, " hilo held"}, {31'd0, stable}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] ohi, olo;
    ohi = m_hi; olo = m_lo;
    issue(op, a, b);
    wait_done(name, op_cycles(op), ohi, olo);
    check32({name, " HI"}, HI, ehi);
    check32({name, " LO"}, LO, elo);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    logic [31:0] ehi, elo, ohi, olo, a, b;
    logic [2:0]  op;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{3'd2, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
    vecs[7] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    reset_n = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    check32("reset busy", {31'd0, busy}, 32'd0);
    check32("reset HI", HI, 32'd0);
    check32("reset LO", LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check32("post-reset idle busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // mthi / mtlo: zero busy cycles, visible the next cycle.
    run_op("mthi", 3'd4, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_1234, m_lo);
    run_op("mtlo", 3'd5, 32'h0000_5678, 32'hDEAD_BEEF, m_hi, 32'h0000_5678);
    run_op("reserved6", 3'd6, 32'hAAAA_AAAA, 32'h1, m_hi, m_lo);

    // Re-pulse during busy must be ignored; the mult result uses the first operands.
    ohi = m_hi; olo = m_lo;
    issue(3'd0, 32'd7, 32'd9);
    start = 1'b1; md_op = 3'd2; A = 32'd100; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("repulse", MULT_N - 1, ohi, olo);
    check32("repulse HI", HI, 32'd0);
    check32("repulse LO", LO, 32'd63);
    m_hi = 32'd0; m_lo = 32'd63;
    // Back-to-back div in the first cycle with busy low.
    run_op("b2b div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      model(op, a, b, m_hi, m_lo, ehi, elo);
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, ehi, elo);
    end

    // Asynchronous reset in the third busy cycle of a div.
    run_op("preset", 3'd4, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, m_lo);
    issue(3'd2, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    check32("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check32("async reset busy", {31'd0, busy}, 32'd0);
    check32("async reset HI", HI, 32'd0);
    check32("async reset LO", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    check32("idle after reset busy", {31'd0, busy}, 32'd0);
    check32("idle after reset HI", HI, 32'd0);
    check32("idle after reset LO", LO, 32'd0);
    run_op("after reset multu", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
